// File: rtl/lc3b_types.sv
// Shared LC-3b types: machine word, opcode field and the fetch-stage state encoding.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [3:0]  lc3b_opcode;

  typedef enum logic [1:0] {
    FETCH_REQ   = 2'd0,
    FETCH_HOLD  = 2'd1,
    FETCH_DRAIN = 2'd2
  } fetch_state_e;

  localparam lc3b_word RESET_PC = 16'h0000;
  localparam lc3b_word PC_STEP  = 16'h0002;

  // Sequential instruction address; relies on 16-bit wrap from 0xFFFE to 0x0000.
  function automatic lc3b_word next_pc(input lc3b_word pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry holding register for a fetched instruction that arrived while the
// output slot was stalled. clear beats load, load beats unload.
module fetch_skid_buffer
  import lc3b_types::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     load,
  input  logic     unload,
  input  logic     clear,
  input  lc3b_word d_ir,
  input  lc3b_word d_pc,
  output lc3b_word buf_ir,
  output lc3b_word buf_pc,
  output logic     buf_valid
);

  lc3b_word buf_ir_q, buf_ir_d;
  lc3b_word buf_pc_q, buf_pc_d;
  logic     buf_valid_q, buf_valid_d;

  always_comb begin
    buf_ir_d    = buf_ir_q;
    buf_pc_d    = buf_pc_q;
    buf_valid_d = buf_valid_q;
    if (clear) begin
      buf_valid_d = 1'b0;
    end else if (load) begin
      buf_ir_d    = d_ir;
      buf_pc_d    = d_pc;
      buf_valid_d = 1'b1;
    end else if (unload) begin
      buf_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_ir_q    <= '0;
      buf_pc_q    <= '0;
      buf_valid_q <= 1'b0;
    end else begin
      buf_ir_q    <= buf_ir_d;
      buf_pc_q    <= buf_pc_d;
      buf_valid_q <= buf_valid_d;
    end
  end

  assign buf_ir    = buf_ir_q;
  assign buf_pc    = buf_pc_q;
  assign buf_valid = buf_valid_q;

endmodule

// File: rtl/fetch_stage.sv
// LC-3b instruction fetch: PC, one-entry output slot backed by a skid buffer,
// and a DRAIN state that swallows the response to a request abandoned by flush.
module fetch_stage
  import lc3b_types::*;
(
  input  logic       clk,
  input  logic       reset,
  output logic       imem_read,
  output lc3b_word   imem_address,
  input  logic       imem_resp,
  input  lc3b_word   imem_rdata,
  input  logic       stall,
  input  logic       flush,
  input  lc3b_word   redirect_pc,
  output logic       valid,
  output lc3b_word   ir,
  output lc3b_word   pc_next,
  output lc3b_opcode opcode,
  output logic       ir5,
  output logic       ir11
);

  fetch_state_e state_q, state_d;
  lc3b_word     pc_q, pc_d;
  lc3b_word     drain_addr_q, drain_addr_d;
  lc3b_word     ir_q, ir_d;
  lc3b_word     pc_next_q, pc_next_d;
  logic         valid_q, valid_d;

  lc3b_word buf_ir, buf_pc;
  logic     buf_valid;
  lc3b_word pc_inc;
  logic     slot_free, consume;
  logic     accept, to_out, to_skid, from_skid;

  assign pc_inc    = next_pc(pc_q);
  assign slot_free = !valid_q || !stall;
  assign consume   = valid_q && !stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH_REQ;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH_REQ: begin
        if (flush)                         state_d = imem_resp ? FETCH_REQ : FETCH_DRAIN;
        else if (imem_resp && !slot_free)  state_d = FETCH_HOLD;
      end
      FETCH_HOLD:  if (flush || !stall) state_d = FETCH_REQ;
      FETCH_DRAIN: if (imem_resp)       state_d = FETCH_REQ;
      default:     state_d = FETCH_REQ;
    endcase
  end

  always_comb begin
    imem_read    = 1'b0;
    imem_address = pc_q;
    accept       = 1'b0;
    to_out       = 1'b0;
    to_skid      = 1'b0;
    from_skid    = 1'b0;
    unique case (state_q)
      FETCH_REQ: begin
        imem_read = 1'b1;
        accept    = imem_resp && !flush;
        to_out    = accept && slot_free;
        to_skid   = accept && !slot_free;
      end
      FETCH_HOLD: from_skid = buf_valid && !flush && !stall;
      FETCH_DRAIN: begin
        imem_read    = 1'b1;
        imem_address = drain_addr_q;
      end
      default: ;
    endcase
    // The request line must drop the moment reset rises, not at the next edge.
    if (reset) imem_read = 1'b0;
  end

  always_comb begin
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    ir_d         = ir_q;
    pc_next_d    = pc_next_q;
    valid_d      = valid_q;
    if (flush) begin
      pc_d    = redirect_pc;
      valid_d = 1'b0;
      if (state_q == FETCH_REQ && !imem_resp) drain_addr_d = pc_q;
    end else begin
      if (accept) pc_d = pc_inc;
      if (to_out) begin
        ir_d      = imem_rdata;
        pc_next_d = pc_inc;
        valid_d   = 1'b1;
      end else if (from_skid) begin
        ir_d      = buf_ir;
        pc_next_d = buf_pc;
        valid_d   = 1'b1;
      end else if (consume) begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q         <= RESET_PC;
      drain_addr_q <= '0;
      ir_q         <= '0;
      pc_next_q    <= '0;
      valid_q      <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      ir_q         <= ir_d;
      pc_next_q    <= pc_next_d;
      valid_q      <= valid_d;
    end
  end

  fetch_skid_buffer u_skid (
    .clk       (clk),
    .reset     (reset),
    .load      (to_skid),
    .unload    (from_skid),
    .clear     (flush),
    .d_ir      (imem_rdata),
    .d_pc      (pc_inc),
    .buf_ir    (buf_ir),
    .buf_pc    (buf_pc),
    .buf_valid (buf_valid)
  );

  assign valid   = valid_q;
  assign ir      = ir_q;
  assign pc_next = pc_next_q;
  assign opcode  = ir_q[15:12];
  assign ir5     = ir_q[5];
  assign ir11    = ir_q[11];

endmodule

// File: tb/tb_fetch_stage.sv
// Fetch stage bench: the stage is modelled as a two-deep instruction queue
// plus an "abandoned request" flag, checked against the DUT every cycle.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_read;
  logic [15:0] imem_address;
  logic        imem_resp;
  logic [15:0] imem_rdata;
  logic        stall;
  logic        flush;
  logic [15:0] redirect_pc;
  logic        valid;
  logic [15:0] ir;
  logic [15:0] pc_next;
  logic [3:0]  opcode;
  logic        ir5;
  logic        ir11;

  fetch_stage dut (
    .clk          (clk),
    .reset        (reset),
    .imem_read    (imem_read),
    .imem_address (imem_address),
    .imem_resp    (imem_resp),
    .imem_rdata   (imem_rdata),
    .stall        (stall),
    .flush        (flush),
    .redirect_pc  (redirect_pc),
    .valid        (valid),
    .ir           (ir),
    .pc_next      (pc_next),
    .opcode       (opcode),
    .ir5          (ir5),
    .ir11         (ir11)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: queue head is the visible instruction, a second entry means the
  // stage is full and stops fetching; m_drain marks an abandoned request in flight.
  typedef struct packed {
    logic [15:0] ir;
    logic [15:0] pc;
  } ent_t;

  ent_t        q[$];
  logic [15:0] m_pc;
  bit          m_drain;
  logic [15:0] m_drain_addr;

  function automatic bit m_fetch();
    return !m_drain && q.size() < 2;
  endfunction

  task automatic model_reset();
    q.delete();
    m_pc         = 16'h0000;
    m_drain      = 1'b0;
    m_drain_addr = 16'h0000;
  endtask

  task automatic model_step();
    bit fetching;
    fetching = m_fetch();
    if (flush) begin
      if (fetching && !imem_resp) begin
        m_drain      = 1'b1;
        m_drain_addr = m_pc;
      end else if (m_drain && imem_resp) begin
        m_drain = 1'b0;
      end
      q.delete();
      m_pc = redirect_pc;
    end else if (m_drain) begin
      if (imem_resp) m_drain = 1'b0;
    end else begin
      if (q.size() > 0 && !stall) void'(q.pop_front());
      if (fetching && imem_resp) begin
        q.push_back('{ir: imem_rdata, pc: m_pc + 16'd2});
        m_pc = m_pc + 16'd2;
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      ent_t e;
      logic exp_read;
      exp_read = m_fetch() || m_drain;
      chk("imem_read", {15'd0, imem_read}, {15'd0, exp_read});
      if (exp_read) chk("imem_address", imem_address, m_drain ? m_drain_addr : m_pc);
      chk("valid", {15'd0, valid}, {15'd0, q.size() > 0});
      if (q.size() > 0) begin
        e = q[0];
        chk("ir", ir, e.ir);
        chk("pc_next", pc_next, e.pc);
        chk("opcode", {12'd0, opcode}, {12'd0, e.ir[15:12]});
        chk("ir5", {15'd0, ir5}, {15'd0, e.ir[5]});
        chk("ir11", {15'd0, ir11}, {15'd0, e.ir[11]});
      end
    end
  end

  // Drive one cycle's inputs (called at a negedge), clock it, advance the model.
  task automatic cyc(input logic s, input logic f, input logic [15:0] rp,
                     input logic r, input logic [15:0] d);
    stall       = s;
    flush       = f;
    redirect_pc = rp;
    imem_resp   = r;
    imem_rdata  = d;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic rnd_cycle();
    logic r;
    logic [15:0] rp;
    r  = (m_fetch() || m_drain) ? ($urandom_range(1) == 0) : ($urandom_range(7) == 0);
    rp = 16'($urandom) & 16'hFFFE;
    cyc($urandom_range(2) == 0, $urandom_range(19) == 0, rp, r, 16'($urandom));
  endtask

  initial begin
    reset = 1'b1;
    stall = 1'b0; flush = 1'b0; redirect_pc = 16'h0; imem_resp = 1'b0; imem_rdata = 16'h0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_valid", {15'd0, valid}, 16'd0);
    chk("rst_ir", ir, 16'h0000);
    chk("rst_pc_next", pc_next, 16'h0000);
    chk("rst_imem_read", {15'd0, imem_read}, 16'd0);
    reset = 1'b0;
    chk_en = 1'b1;
    #1;
    chk("first_req_read", {15'd0, imem_read}, 16'd1);
    chk("first_req_addr", imem_address, 16'h0000);

    // Two back-to-back fetches, each answered one cycle after its request.
    cyc(1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    cyc(1'b0, 1'b0, 16'h0, 1'b1, 16'h1234);
    chk("seq_valid", {15'd0, valid}, 16'd1);
    chk("seq_ir0", ir, 16'h1234);
    chk("seq_pcn0", pc_next, 16'h0002);
    chk("seq_opcode0", {12'd0, opcode}, 16'h0001);
    cyc(1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    cyc(1'b0, 1'b0, 16'h0, 1'b1, 16'h5678);
    chk("seq_ir1", ir, 16'h5678);
    chk("seq_pcn1", pc_next, 16'h0004);
    chk("seq_ir5", {15'd0, ir5}, 16'd1);
    chk("seq_ir11", {15'd0, ir11}, 16'd0);

    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 16'h0, 1'b1, 16'($urandom));
    chk("pre_flush_addr", imem_address, 16'h0010);

    // Flush while the request to 0x0010 is outstanding; answer arrives 3 cycles later.
    cyc(1'b0, 1'b1, 16'h3000, 1'b0, 16'h0);
    chk("drain_valid", {15'd0, valid}, 16'd0);
    chk("drain_addr0", imem_address, 16'h0010);
    cyc(1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    cyc(1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    chk("drain_addr2", imem_address, 16'h0010);
    cyc(1'b0, 1'b0, 16'h0, 1'b1, 16'hDEAD);
    chk("drain_discard", {15'd0, valid}, 16'd0);
    chk("redirect_addr", imem_address, 16'h3000);

    // Stalled output: response parks in the skid buffer, fetch pauses.
    cyc(1'b0, 1'b0, 16'h0, 1'b1, 16'h1111);
    chk("pre_hold_ir", ir, 16'h1111);
    cyc(1'b1, 1'b0, 16'h0, 1'b1, 16'hABCD);
    chk("hold_read", {15'd0, imem_read}, 16'd0);
    chk("hold_ir", ir, 16'h1111);
    cyc(1'b1, 1'b0, 16'h0, 1'b1, 16'h7777);
    chk("hold_stray_ir", ir, 16'h1111);
    cyc(1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    chk("unhold_ir", ir, 16'hABCD);
    chk("unhold_pcn", pc_next, 16'h3004);
    chk("unhold_read", {15'd0, imem_read}, 16'd1);
    chk("unhold_addr", imem_address, 16'h3004);

    cyc(1'b0, 1'b1, 16'h3000, 1'b1, 16'h9999);
    chk("flush_resp_valid", {15'd0, valid}, 16'd0);
    chk("flush_resp_addr", imem_address, 16'h3000);

    // PC wrap at the top of the address space.
    cyc(1'b0, 1'b1, 16'hFFFE, 1'b1, 16'h0);
    chk("wrap_pre_addr", imem_address, 16'hFFFE);
    cyc(1'b0, 1'b0, 16'h0, 1'b1, 16'h2222);
    chk("wrap_pcn", pc_next, 16'h0000);
    chk("wrap_addr", imem_address, 16'h0000);

    for (int i = 0; i < 3000; i++) rnd_cycle();

    // Reach HOLD, then raise reset between clock edges.
    cyc(1'b0, 1'b1, 16'h4000, 1'b1, 16'h0);
    cyc(1'b0, 1'b0, 16'h0, 1'b1, 16'h5555);
    cyc(1'b1, 1'b0, 16'h0, 1'b1, 16'h6666);
    chk("pre_async_hold", {15'd0, imem_read}, 16'd0);
    chk_en = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("async_valid", {15'd0, valid}, 16'd0);
    chk("async_ir", ir, 16'h0000);
    chk("async_pcn", pc_next, 16'h0000);
    chk("async_read", {15'd0, imem_read}, 16'd0);
    chk("async_opcode", {12'd0, opcode}, 16'd0);
    @(negedge clk);
    model_reset();
    stall = 1'b0; flush = 1'b0; imem_resp = 1'b0;
    reset = 1'b0;
    chk_en = 1'b1;
    #1;
    chk("post_rst_addr", imem_address, 16'h0000);
    chk("post_rst_read", {15'd0, imem_read}, 16'd1);
    @(negedge clk);
    for (int i = 0; i < 300; i++) rnd_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
